shift_reg_ctrl: RTL

Sequencer for the team's D-flip-flop shift-register datapath. It takes a WIDTH-bit parallel word through a valid/ready handshake, loads it into an internal register bank, and streams it out serially, one bit per DIV clocks. Bit order is selectable per word. It is the control layer placed in front of serial links built from the PIPO/PISO register chain.

---
 rtl/shift_reg_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/shift_reg_ctrl.sv
// Word-to-serial sequencer: accepts a parallel word over valid/ready, then
// streams it out one bit per DIV clocks in the selected bit order.
module shift_reg_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_lsb_first,
  input  logic                       abort,
  output logic                       ser_out,
  output logic                       ser_en,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             order_q, order_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_en_q, ser_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_last;

  assign div_last = (DIV == 1) ? 1'b1 : (div_q == DW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    order_d = order_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_data;
          order_d = in_lsb_first;
          div_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          div_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (div_last) begin
          div_d  = '0;
          sreg_d = order_q ? (sreg_q >> 1) : (sreg_q << 1);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so derive them from the next-state values.
    ser_en_d  = (state_d == SHIFT);
    ser_out_d = (state_d == SHIFT) &&
                (order_d ? sreg_d[0] : sreg_d[WIDTH-1]);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      order_q   <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      ser_out_q <= 1'b0;
      ser_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      order_q   <= order_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ser_out_q <= ser_out_d;
      ser_en_q  <= ser_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;
  assign ser_out  = ser_out_q;
  assign ser_en   = ser_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_cnt  = cnt_q;

endmodule
